// File: rtl/iso_cube_renderer.sv
// iso_cube_renderer
// Per-pixel isometric cube renderer. Each scan position is classified as
// the left, right or top face of a cube (or background) using exact
// cross-multiplied edge tests, and the matching RGB colour is produced
// three clocks later. Cube geometry is runtime-loadable through a
// valid/ready slot and only takes effect at a frame-start pixel, so a frame
// is always drawn with one consistent geometry. The top face can be
// highlighted, either steadily or blinking on a frame-count schedule.

module iso_cube_renderer #(
  parameter int          XW           = 11,
  parameter int          YW           = 10,
  parameter int          DEF_X0       = 100,
  parameter int          DEF_Y0       = 100,
  parameter int          DEF_W        = 100,
  parameter int          DEF_DX       = 30,
  parameter int          DEF_DY       = 50,
  parameter logic [23:0] LEFT_RGB     = 24'h56A998,
  parameter logic [23:0] RIGHT_RGB    = 24'h314646,
  parameter logic [23:0] TOP_RGB      = 24'h5646EF,
  parameter logic [23:0] HL_RGB       = 24'hDEDE00,
  parameter logic [23:0] BG_RGB       = 24'h000000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] Xpos,
  input  logic [YW-1:0] Ypos,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [XW-1:0] cfg_x0,
  input  logic [YW-1:0] cfg_y0,
  input  logic [XW-1:0] cfg_w,
  input  logic [XW-1:0] cfg_dx,
  input  logic [YW-1:0] cfg_dy,
  input  logic          top_cube,
  input  logic          blink_en,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          cube_hit
);

  // Geometry arithmetic width (differences) and product width.
  localparam int GW = XW + YW + 2;
  localparam int PW = 2 * GW;
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Active geometry used for rendering and the pending slot.
  logic [XW-1:0] act_x0, act_w, act_dx;
  logic [YW-1:0] act_y0, act_dy;
  logic [XW-1:0] pend_x0, pend_w, pend_dx;
  logic [YW-1:0] pend_y0, pend_dy;

  // Blink state.
  logic [CW-1:0] blink_cnt;
  logic          phase;

  // Frame-start and handshake decode.
  logic frame_start;
  logic swap;
  logic accept;
  logic blink_wrap;

  // Geometry seen by the pixel currently entering the pipeline.
  logic [XW-1:0] geo_x0, geo_w, geo_dx;
  logic [YW-1:0] geo_y0, geo_dy;

  // Stage-0 signed operands and results.
  logic signed [GW-1:0] xs, ys, x0s, y0s, ws, dxs, dys;
  logic signed [GW-1:0] s0_u, s0_uw, s0_r, s0_v;
  logic                 s0_upper, s0_lower, s0_degen, s0_phase, s0_hl;

  // Stage-1 registers.
  logic signed [GW-1:0] s1_u, s1_uw, s1_r, s1_v, s1_dx, s1_dy;
  logic                 s1_upper, s1_lower, s1_degen, s1_hl;

  // Stage-2 registers.
  logic signed [PW-1:0] s2_pu, s2_puw, s2_pr, s2_pv;
  logic                 s2_upper, s2_lower, s2_degen, s2_hl;

  // Stage-3 combinational classification.
  logic signed [PW-1:0] s3_rv;
  logic                 s3_edge_in, s3_top_in;
  logic [23:0]          s3_rgb;
  logic                 s3_hit;

  assign frame_start = (Xpos == '0) && (Ypos == '0);
  // A full slot is committed on the frame-start pixel; an empty slot accepts.
  assign swap        = frame_start && !cfg_ready;
  assign accept      = cfg_valid && cfg_ready;
  assign blink_wrap  = (blink_cnt == CW'(BLINK_FRAMES - 1));

  // Config slot: capture offered geometry, commit it at the next frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_x0    <= XW'(DEF_X0);
      act_y0    <= YW'(DEF_Y0);
      act_w     <= XW'(DEF_W);
      act_dx    <= XW'(DEF_DX);
      act_dy    <= YW'(DEF_DY);
      pend_x0   <= '0;
      pend_y0   <= '0;
      pend_w    <= '0;
      pend_dx   <= '0;
      pend_dy   <= '0;
      cfg_ready <= 1'b1;
    end else if (swap) begin
      act_x0    <= pend_x0;
      act_y0    <= pend_y0;
      act_w     <= pend_w;
      act_dx    <= pend_dx;
      act_dy    <= pend_dy;
      cfg_ready <= 1'b1;
    end else if (accept) begin
      pend_x0   <= cfg_x0;
      pend_y0   <= cfg_y0;
      pend_w    <= cfg_w;
      pend_dx   <= cfg_dx;
      pend_dy   <= cfg_dy;
      cfg_ready <= 1'b0;
    end
  end

  // Blink schedule: count frame starts, toggle the phase every BLINK_FRAMES.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_start) begin
      if (blink_wrap) begin
        blink_cnt <= '0;
        phase     <= !phase;
      end else begin
        blink_cnt <= blink_cnt + CW'(1);
      end
    end
  end

  // The frame-start pixel already belongs to the new frame, so it sees the
  // geometry being committed on this very edge.
  always_comb begin
    geo_x0 = act_x0;
    geo_y0 = act_y0;
    geo_w  = act_w;
    geo_dx = act_dx;
    geo_dy = act_dy;
    if (swap) begin
      geo_x0 = pend_x0;
      geo_y0 = pend_y0;
      geo_w  = pend_w;
      geo_dx = pend_dx;
      geo_dy = pend_dy;
    end
  end

  // Stage 0: offsets relative to the anchor, band decode, highlight choice.
  always_comb begin
    xs  = $signed(GW'(Xpos));
    ys  = $signed(GW'(Ypos));
    x0s = $signed(GW'(geo_x0));
    y0s = $signed(GW'(geo_y0));
    ws  = $signed(GW'(geo_w));
    dxs = $signed(GW'(geo_dx));
    dys = $signed(GW'(geo_dy));

    s0_u     = xs - x0s;
    s0_uw    = s0_u - ws;
    s0_r     = ys - y0s;
    s0_v     = (dys + dys) - s0_r;
    s0_upper = !s0_r[GW-1] && (s0_r < dys);
    s0_lower = (s0_r >= dys) && (s0_r <= (dys + dys));
    s0_degen = (geo_w == '0) || (geo_dy == '0);

    // Phase this pixel's frame will run with, including a toggle on this edge.
    s0_phase = phase;
    if (!blink_en) begin
      s0_phase = 1'b1;
    end else if (frame_start && blink_wrap) begin
      s0_phase = !phase;
    end
    s0_hl = top_cube && s0_phase;
  end

  // Stage 1: register offsets, band flags and the pixel's own slope terms.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_u     <= '0;
      s1_uw    <= '0;
      s1_r     <= '0;
      s1_v     <= '0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_upper <= 1'b0;
      s1_lower <= 1'b0;
      s1_degen <= 1'b1;
      s1_hl    <= 1'b0;
    end else begin
      s1_u     <= s0_u;
      s1_uw    <= s0_uw;
      s1_r     <= s0_r;
      s1_v     <= s0_v;
      s1_dx    <= dxs;
      s1_dy    <= dys;
      s1_upper <= s0_upper;
      s1_lower <= s0_lower;
      s1_degen <= s0_degen;
      s1_hl    <= s0_hl;
    end
  end

  // Stage 2: the four cross products used by the edge tests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_pu    <= '0;
      s2_puw   <= '0;
      s2_pr    <= '0;
      s2_pv    <= '0;
      s2_upper <= 1'b0;
      s2_lower <= 1'b0;
      s2_degen <= 1'b1;
      s2_hl    <= 1'b0;
    end else begin
      s2_pu    <= PW'(s1_u)  * PW'(s1_dy);
      s2_puw   <= PW'(s1_uw) * PW'(s1_dy);
      s2_pr    <= PW'(s1_r)  * PW'(s1_dx);
      s2_pv    <= PW'(s1_v)  * PW'(s1_dx);
      s2_upper <= s1_upper;
      s2_lower <= s1_lower;
      s2_degen <= s1_degen;
      s2_hl    <= s1_hl;
    end
  end

  // Stage 3 decode: the band picks r or v; LEFT beats RIGHT beats TOP.
  always_comb begin
    s3_rv      = s2_upper ? s2_pr : s2_pv;
    s3_edge_in = (s2_pu >= s3_rv) && (s2_puw <= s3_rv);
    s3_top_in  = ((-s2_pu) <= s3_rv) && (s2_pu < s3_rv);
    s3_rgb     = BG_RGB;
    s3_hit     = 1'b0;
    if (!s2_degen) begin
      if (s2_upper && s3_edge_in) begin
        s3_rgb = LEFT_RGB;
        s3_hit = 1'b1;
      end else if (s2_lower && s3_edge_in) begin
        s3_rgb = RIGHT_RGB;
        s3_hit = 1'b1;
      end else if ((s2_upper || s2_lower) && s3_top_in) begin
        s3_rgb = s2_hl ? HL_RGB : TOP_RGB;
        s3_hit = 1'b1;
      end
    end
  end

  // Stage 3: registered pixel outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      red      <= 8'h00;
      green    <= 8'h00;
      blue     <= 8'h00;
      cube_hit <= 1'b0;
    end else begin
      red      <= s3_rgb[23:16];
      green    <= s3_rgb[15:8];
      blue     <= s3_rgb[7:0];
      cube_hit <= s3_hit;
    end
  end

endmodule

// File: tb/tb_iso_cube_renderer.sv
// tb_iso_cube_renderer
// Directed pixel vectors with hand-computed colours. Expected results are
// queued when a pixel is issued; a monitor pops them when that pixel
// reaches the outputs three clocks later.

`timescale 1ns/1ps

module tb_iso_cube_renderer;

  localparam int XW = 11;
  localparam int YW = 10;

  localparam logic [23:0] LEFT_C  = 24'h56A998;
  localparam logic [23:0] RIGHT_C = 24'h314646;
  localparam logic [23:0] TOP_C   = 24'h5646EF;
  localparam logic [23:0] HL_C    = 24'hDEDE00;
  localparam logic [23:0] BG_C    = 24'h000000;

  logic          clk;
  logic          reset;
  logic [XW-1:0] Xpos;
  logic [YW-1:0] Ypos;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [XW-1:0] cfg_x0;
  logic [YW-1:0] cfg_y0;
  logic [XW-1:0] cfg_w;
  logic [XW-1:0] cfg_dx;
  logic [YW-1:0] cfg_dy;
  logic          top_cube;
  logic          blink_en;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;
  logic          cube_hit;

  iso_cube_renderer #(
    .XW           (XW),
    .YW           (YW),
    .BLINK_FRAMES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Xpos      (Xpos),
    .Ypos      (Ypos),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_x0    (cfg_x0),
    .cfg_y0    (cfg_y0),
    .cfg_w     (cfg_w),
    .cfg_dx    (cfg_dx),
    .cfg_dy    (cfg_dy),
    .top_cube  (top_cube),
    .blink_en  (blink_en),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .cube_hit  (cube_hit)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected {hit, rgb} plus a short name per tagged pixel.
  logic [24:0] exp_q[$];
  string       name_q[$];
  logic        issue;
  logic [2:0]  tag_pipe;
  int          n_cmp;
  int          n_fail;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Tag tracker: marks which output cycles belong to a tagged pixel.
  always @(posedge clk or negedge reset) begin
    if (!reset) tag_pipe <= 3'b000;
    else        tag_pipe <= {tag_pipe[1:0], issue};
  end

  // Monitor: compare outputs against the scoreboard away from the clock edge.
  always @(negedge clk) begin
    if (tag_pipe[2]) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL scoreboard_underflow: got %h, expected nothing",
                 {cube_hit, red, green, blue});
      end else begin
        check_output(name_q.pop_front(), {7'b0, cube_hit, red, green, blue},
                     {7'b0, exp_q.pop_front()});
      end
    end
  end

  // Drive one pixel for one cycle; optionally queue its expected colour.
  task automatic apply_stimulus(input int x, input int y, input bit chk,
                                input logic [23:0] rgb, input string name);
    Xpos  = XW'(x);
    Ypos  = YW'(y);
    issue = chk;
    if (chk) begin
      exp_q.push_back({(rgb != BG_C), rgb});
      name_q.push_back(name);
    end
    @(posedge clk);
    #1;
    issue     = 1'b0;
    cfg_valid = 1'b0;
  endtask

  // Offer a geometry on the next driven pixel cycle.
  task automatic send_cfg(input int x0, input int y0, input int w,
                          input int dx, input int dy);
    cfg_x0    = XW'(x0);
    cfg_y0    = YW'(y0);
    cfg_w     = XW'(w);
    cfg_dx    = XW'(dx);
    cfg_dy    = YW'(dy);
    cfg_valid = 1'b1;
  endtask

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [23:0] blink_exp [6];

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    issue     = 1'b0;
    reset     = 1'b0;
    Xpos      = XW'(5);
    Ypos      = YW'(5);
    cfg_valid = 1'b0;
    cfg_x0    = XW'(100);
    cfg_y0    = YW'(100);
    cfg_w     = XW'(100);
    cfg_dx    = XW'(30);
    cfg_dy    = YW'(50);
    top_cube  = 1'b0;
    blink_en  = 1'b0;
    blink_exp = '{HL_C, HL_C, TOP_C, TOP_C, HL_C, HL_C};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_pixel", {7'b0, cube_hit, red, green, blue}, 32'h0);
    check_output("reset_cfg_ready", {31'b0, cfg_ready}, 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Default geometry: faces, background and band/edge boundaries.
    apply_stimulus(150, 110, 1, LEFT_C,  "def_left");
    apply_stimulus(120, 170, 1, RIGHT_C, "def_right");
    apply_stimulus(50,  100, 1, BG_C,    "def_bg");
    top_cube = 1'b1;
    apply_stimulus(90,  120, 1, HL_C,    "def_top_hl");
    top_cube = 1'b0;
    apply_stimulus(90,  120, 1, TOP_C,   "def_top");
    apply_stimulus(100, 100, 1, LEFT_C,  "corner_left_wins");
    apply_stimulus(88,  120, 1, TOP_C,   "top_left_edge_in");
    apply_stimulus(87,  120, 1, BG_C,    "top_left_edge_out");
    apply_stimulus(212, 120, 1, LEFT_C,  "left_right_edge_in");
    apply_stimulus(213, 120, 1, BG_C,    "left_right_edge_out");
    apply_stimulus(120, 150, 1, TOP_C,   "lower_band_top");
    apply_stimulus(120, 200, 1, RIGHT_C, "lower_band_last_row");
    apply_stimulus(120, 201, 1, BG_C,    "below_cube");
    apply_stimulus(120, 99,  1, BG_C,    "above_cube");

    // Mid-frame config: held back until the next frame start.
    send_cfg(300, 100, 100, 30, 50);
    check_output("cfg_ready_idle", {31'b0, cfg_ready}, 32'h1);
    apply_stimulus(5, 5, 0, BG_C, "");
    check_output("cfg_ready_after_accept", {31'b0, cfg_ready}, 32'h0);
    apply_stimulus(350, 110, 1, BG_C, "pending_not_applied");
    send_cfg(500, 100, 100, 30, 50);
    apply_stimulus(5, 5, 0, BG_C, "");
    check_output("cfg_ready_busy", {31'b0, cfg_ready}, 32'h0);
    apply_stimulus(0, 0, 0, BG_C, "");
    check_output("cfg_ready_after_frame", {31'b0, cfg_ready}, 32'h1);
    apply_stimulus(350, 110, 1, LEFT_C, "x300_applied_left");
    apply_stimulus(150, 110, 1, BG_C,   "x300_old_spot_bg");

    // Config offered on the frame-start pixel waits one more frame.
    send_cfg(100, 100, 100, 30, 50);
    apply_stimulus(0, 0, 0, BG_C, "");
    check_output("cfg_ready_fs_accept", {31'b0, cfg_ready}, 32'h0);
    apply_stimulus(150, 110, 1, BG_C,   "fs_accept_old_bg");
    apply_stimulus(350, 110, 1, LEFT_C, "fs_accept_old_left");
    apply_stimulus(0, 0, 0, BG_C, "");
    apply_stimulus(150, 110, 1, LEFT_C, "fs_accept_new_left");
    apply_stimulus(350, 110, 1, BG_C,   "fs_accept_new_bg");

    // Degenerate geometry: DY=0 blanks the whole frame.
    send_cfg(100, 100, 100, 30, 0);
    apply_stimulus(5, 5, 0, BG_C, "");
    apply_stimulus(0, 0, 0, BG_C, "");
    top_cube = 1'b1;
    apply_stimulus(150, 110, 1, BG_C, "dy0_left_spot");
    apply_stimulus(100, 100, 1, BG_C, "dy0_anchor");
    apply_stimulus(120, 170, 1, BG_C, "dy0_right_spot");
    apply_stimulus(90,  120, 1, BG_C, "dy0_top_spot");
    top_cube = 1'b0;
    send_cfg(100, 100, 100, 30, 50);
    apply_stimulus(5, 5, 0, BG_C, "");
    apply_stimulus(0, 0, 0, BG_C, "");
    apply_stimulus(150, 110, 1, LEFT_C, "restored_left");

    // Blink: two frames highlighted, two plain, two highlighted.
    top_cube = 1'b1;
    blink_en = 1'b1;
    apply_stimulus(90, 120, 1, blink_exp[0], "blink_f0");
    for (int f = 1; f < 6; f++) begin
      apply_stimulus(0, 0, 0, BG_C, "");
      apply_stimulus(90, 120, 1, blink_exp[f], $sformatf("blink_f%0d", f));
    end
    blink_en = 1'b0;
    top_cube = 1'b0;

    // Asynchronous reset mid-line with a config pending.
    send_cfg(300, 100, 100, 30, 50);
    apply_stimulus(5, 5, 0, BG_C, "");
    repeat (4) apply_stimulus(150, 110, 0, BG_C, "");
    check_output("pre_reset_left", {7'b0, cube_hit, red, green, blue},
                 {7'b0, 1'b1, LEFT_C});
    check_output("pre_reset_cfg_busy", {31'b0, cfg_ready}, 32'h0);
    #3;
    reset = 1'b0;
    #1;
    check_output("async_reset_pixel", {7'b0, cube_hit, red, green, blue}, 32'h0);
    check_output("async_reset_cfg_ready", {31'b0, cfg_ready}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply_stimulus(350, 110, 1, BG_C,   "post_reset_default_bg");
    apply_stimulus(150, 110, 1, LEFT_C, "post_reset_left");
    apply_stimulus(0, 0, 0, BG_C, "");
    apply_stimulus(350, 110, 1, BG_C,   "pending_discarded_bg");
    check_output("post_reset_cfg_ready", {31'b0, cfg_ready}, 32'h1);

    // Drain the pipeline with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      apply_stimulus(5, 5, 0, BG_C, "");
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
